// File: rtl/spi_slave_ctrl_burst.sv
// Control FSM for the SPI slave datapath: sequences address, R/W, load and data
// phases with configurable widths and an optional auto-increment burst mode.
module spi_slave_ctrl_burst #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sclk_pos,
    input  logic rw_bit,
    output logic miso_buff,
    output logic dm_we,
    output logic addr_we,
    output logic sr_we,
    output logic addr_inc,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(ADDR_W + DATA_W + 2);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
    localparam logic             BURST     = (AUTO_INC != 0);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ_LOAD,
        READ,
        WRITE,
        WRITE_DM,
        WRITE_INC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             miso_buff_d, dm_we_d, addr_we_d, sr_we_d, addr_inc_d, busy_d;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            miso_buff <= 1'b0;
            dm_we     <= 1'b0;
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
            addr_inc  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            miso_buff <= miso_buff_d;
            dm_we     <= dm_we_d;
            addr_we   <= addr_we_d;
            sr_we     <= sr_we_d;
            addr_inc  <= addr_inc_d;
            busy      <= busy_d;
        end
    end

    // Next state, next counter and next output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miso_buff_d = 1'b0;
        dm_we_d     = 1'b0;
        addr_we_d   = 1'b0;
        sr_we_d     = 1'b0;
        addr_inc_d  = 1'b0;

        if (cs) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            // Strobes seen in the one-cycle states carry into the next word
            if (sclk_pos) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
                ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        addr_we_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = rw_bit ? READ_LOAD : WRITE;
                    end
                end
                READ_LOAD: begin
                    sr_we_d     = 1'b1;
                    miso_buff_d = 1'b1;
                    state_d     = READ;
                end
                READ: begin
                    miso_buff_d = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
                        if (BURST) begin
                            addr_inc_d = 1'b1;
                            state_d    = READ_LOAD;
                        end else begin
                            miso_buff_d = 1'b0;
                            state_d     = DONE;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE_DM;
                    end
                end
                WRITE_DM: begin
                    dm_we_d = 1'b1;
                    if (BURST) begin
                        state_d = WRITE_INC;
                    end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                WRITE_INC: begin
                    addr_inc_d = 1'b1;
                    state_d    = WRITE;
                end
                DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_slave_ctrl_burst.sv
// Self-checking bench: three controller configurations driven by shared stimulus
// and compared every cycle against a strobe-counting frame model.
module tb_spi_slave_ctrl_burst;

    localparam int NDUT = 3;
    localparam longint MAXT = 64'h7fff_ffff_ffff;

    logic clk = 1'b0;
    logic rst_n, cs, sclk_pos, rw_bit;
    logic [NDUT-1:0] miso, dm, awe, sr, inc, busy;

    always #5 clk = ~clk;

    spi_slave_ctrl_burst #(.ADDR_W(7), .DATA_W(8), .AUTO_INC(1)) u_burst (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk_pos(sclk_pos), .rw_bit(rw_bit),
        .miso_buff(miso[0]), .dm_we(dm[0]), .addr_we(awe[0]), .sr_we(sr[0]),
        .addr_inc(inc[0]), .busy(busy[0]));

    spi_slave_ctrl_burst #(.ADDR_W(7), .DATA_W(8), .AUTO_INC(0)) u_single (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk_pos(sclk_pos), .rw_bit(rw_bit),
        .miso_buff(miso[1]), .dm_we(dm[1]), .addr_we(awe[1]), .sr_we(sr[1]),
        .addr_inc(inc[1]), .busy(busy[1]));

    spi_slave_ctrl_burst #(.ADDR_W(3), .DATA_W(5), .AUTO_INC(1)) u_narrow (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk_pos(sclk_pos), .rw_bit(rw_bit),
        .miso_buff(miso[2]), .dm_we(dm[2]), .addr_we(awe[2]), .sr_we(sr[2]),
        .addr_inc(inc[2]), .busy(busy[2]));

    function automatic int pa(input int d);
        return (d == 2) ? 3 : 7;
    endfunction
    function automatic int pd(input int d);
        return (d == 2) ? 5 : 8;
    endfunction
    function automatic bit pi(input int d);
        return (d != 1);
    endfunction

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;

    // Frame model: strobe index within the frame decides every pulse
    bit         in_frame [NDUT];
    int         n_str    [NDUT];
    bit         done     [NDUT];
    bit         is_read  [NDUT];
    longint     rw_at    [NDUT];
    longint     m_start  [NDUT];
    longint     m_stop   [NDUT];
    logic [3:0] ring     [NDUT][8];   // {dm, awe, sr, inc} per future cycle
    logic [5:0] exp_v    [NDUT];

    int     tot_awe [NDUT], tot_dm [NDUT], tot_sr [NDUT], tot_inc [NDUT];
    int     s_awe   [NDUT], s_dm   [NDUT], s_sr   [NDUT], s_inc   [NDUT];
    longint last_awe [NDUT], last_dm [NDUT], last_sr [NDUT];
    longint se [0:63];

    task automatic sch(input int d, input longint t, input int b);
        ring[d][int'(t % 8)][b] = 1'b1;
    endtask

    task automatic model_step(input int d, output logic [5:0] e);
        int a, w, slot;
        bit ai;
        a = pa(d); w = pd(d); ai = pi(d);
        slot = int'(cyc % 8);
        e = '0;
        if (!rst_n || cs) begin
            in_frame[d] = 1'b0;
            for (int s = 0; s < 8; s++) ring[d][s] = '0;
            return;
        end
        if (!in_frame[d]) begin
            in_frame[d] = 1'b1;
            n_str[d] = 0; done[d] = 1'b0; is_read[d] = 1'b0;
            rw_at[d] = -1; m_start[d] = MAXT; m_stop[d] = MAXT;
            e[0] = 1'b1;
            return;
        end
        if (cyc == rw_at[d]) begin
            is_read[d] = rw_bit;
            if (rw_bit) begin
                sch(d, cyc + 1, 1);
                m_start[d] = cyc + 1;
            end
        end
        if (sclk_pos && !done[d]) begin
            n_str[d]++;
            if (n_str[d] == a + 1) begin
                sch(d, cyc + 1, 2);
                rw_at[d] = cyc + 1;
            end else if (n_str[d] > a + 1 && (n_str[d] - a - 1) % w == 0) begin
                if (is_read[d]) begin
                    if (ai) begin
                        sch(d, cyc + 1, 0);
                        sch(d, cyc + 2, 1);
                    end else begin
                        m_stop[d] = cyc + 1;
                        done[d] = 1'b1;
                    end
                end else begin
                    sch(d, cyc + 2, 3);
                    if (ai) sch(d, cyc + 3, 0);
                    else done[d] = 1'b1;
                end
            end
        end
        e = {(cyc >= m_start[d] && cyc < m_stop[d]), ring[d][slot], 1'b1};
        ring[d][slot] = '0;
    endtask

    // Compare process: model advanced on each edge, DUT sampled 1 time unit later
    initial begin
        for (int d = 0; d < NDUT; d++) begin
            in_frame[d] = 1'b0;
            tot_awe[d] = 0; tot_dm[d] = 0; tot_sr[d] = 0; tot_inc[d] = 0;
            last_awe[d] = -1; last_dm[d] = -1; last_sr[d] = -1;
            for (int s = 0; s < 8; s++) ring[d][s] = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < NDUT; d++) model_step(d, exp_v[d]);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                logic [5:0] act;
                act = {miso[d], dm[d], awe[d], sr[d], inc[d], busy[d]};
                checks++;
                if (act !== exp_v[d]) begin
                    errors++;
                    $display("FAIL outputs dut%0d cyc %0d: {miso,dm,awe,sr,inc,busy} got %b want %b",
                             d, cyc, act, exp_v[d]);
                end
                tot_awe[d] += int'(awe[d]);
                tot_dm[d]  += int'(dm[d]);
                tot_sr[d]  += int'(sr[d]);
                tot_inc[d] += int'(inc[d]);
                if (awe[d]) last_awe[d] = cyc;
                if (dm[d])  last_dm[d]  = cyc;
                if (sr[d])  last_sr[d]  = cyc;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic snap();
        for (int d = 0; d < NDUT; d++) begin
            s_awe[d] = tot_awe[d]; s_dm[d] = tot_dm[d];
            s_sr[d]  = tot_sr[d];  s_inc[d] = tot_inc[d];
        end
    endtask

    task automatic drive_rw(input int mode);
        if (mode == 2) rw_bit = 1'($urandom_range(0, 1));
        else           rw_bit = 1'(mode);
    endtask

    task automatic idle_cyc(input int mode);
        @(negedge clk);
        sclk_pos = 1'b0;
        drive_rw(mode);
    endtask

    // cs low, nstr strobes spaced 3..gap_max clocks, then tail idle clocks; cs left low
    task automatic frame(input int nstr, input int mode, input int lead,
                         input int gap_max, input int tail);
        @(negedge clk);
        cs = 1'b0; sclk_pos = 1'b0;
        drive_rw(mode);
        for (int k = 1; k < lead; k++) idle_cyc(mode);
        for (int i = 1; i <= nstr; i++) begin
            if (!(i == 1 && lead == 0)) @(negedge clk);
            sclk_pos = 1'b1;
            drive_rw(mode);
            se[i] = cyc + 1;
            repeat ($urandom_range(2, gap_max - 1)) idle_cyc(mode);
        end
        repeat (tail) idle_cyc(mode);
    endtask

    task automatic end_frame(input int hold);
        @(negedge clk);
        cs = 1'b1; sclk_pos = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; sclk_pos = 1'b0; rw_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", longint'({miso, dm, awe, sr, inc, busy}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, no burst config
        snap();
        frame(16, 0, 2, 3, 4);
        chk("single_write_busy_in_done", longint'(busy[1]), 1);
        end_frame(2);
        chk("single_write_awe_count", tot_awe[1] - s_awe[1], 1);
        chk("single_write_dm_count",  tot_dm[1] - s_dm[1], 1);
        chk("single_write_sr_count",  tot_sr[1] - s_sr[1], 0);
        chk("single_write_inc_count", tot_inc[1] - s_inc[1], 0);
        chk("single_write_awe_time",  last_awe[1], se[8] + 1);
        chk("single_write_dm_time",   last_dm[1], se[16] + 2);

        // Single read
        snap();
        frame(16, 1, 1, 3, 4);
        end_frame(2);
        chk("single_read_sr_count", tot_sr[1] - s_sr[1], 1);
        chk("single_read_sr_time",  last_sr[1], se[8] + 2);
        chk("single_read_dm_count", tot_dm[1] - s_dm[1], 0);

        // 32-strobe write on all configs, tightest strobe spacing
        snap();
        frame(32, 0, 1, 3, 4);
        end_frame(2);
        chk("burst_write_dm_count",   tot_dm[0] - s_dm[0], 3);
        chk("burst_write_inc_count",  tot_inc[0] - s_inc[0], 3);
        chk("burst_write_awe_count",  tot_awe[0] - s_awe[0], 1);
        chk("nobust_write_dm_count",  tot_dm[1] - s_dm[1], 1);
        chk("narrow_write_dm_count",  tot_dm[2] - s_dm[2], 5);
        chk("narrow_write_inc_count", tot_inc[2] - s_inc[2], 5);

        // 24-strobe burst read
        snap();
        frame(24, 1, 1, 3, 4);
        end_frame(2);
        chk("burst_read_sr_count",  tot_sr[0] - s_sr[0], 3);
        chk("burst_read_inc_count", tot_inc[0] - s_inc[0], 2);
        chk("burst_read_sr_time",   last_sr[0], se[24] + 2);

        // Abort mid-word, then a normal frame
        snap();
        frame(12, 0, 1, 4, 0);
        end_frame(2);
        chk("abort_dm_count_single", tot_dm[1] - s_dm[1], 0);
        chk("abort_dm_count_burst",  tot_dm[0] - s_dm[0], 0);
        chk("abort_busy",            longint'(busy), 0);
        snap();
        frame(16, 0, 1, 4, 4);
        end_frame(2);
        chk("after_abort_dm_count", tot_dm[1] - s_dm[1], 1);

        // Asynchronous reset in the middle of a read
        frame(12, 1, 1, 3, 1);
        chk("pre_reset_miso", longint'(miso[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", longint'({miso, dm, awe, sr, inc, busy}), 0);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", longint'(busy), 0);

        // Randomised frames against the model
        repeat (60) begin
            frame($urandom_range(0, 40), 2, $urandom_range(0, 2),
                  $urandom_range(3, 6), $urandom_range(0, 4));
            end_frame($urandom_range(1, 3));
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
